// File: rtl/video_timing_pkg.sv
// Shared timing constants and segment-decode helpers for video_timing_gen.
//
// Contents:
//   timing_preset_t    - one complete set of raster timing constants
//   VT_1280X1024_60    - 1280x1024 @ 60 Hz (108 MHz pixel clock)
//   VT_640X480_60      - 640x480 @ 60 Hz (25.175 MHz pixel clock)
//   seg_total()        - line/frame length from the four segment lengths
//   in_visible()       - count lies in the visible segment
//   in_sync()          - count lies in the sync segment (the last segment)
//
// Segment order on both axes: back porch, visible, front porch, sync.
package video_timing_pkg;

  typedef struct packed {
    int   h_visible;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_visible;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } timing_preset_t;

  localparam timing_preset_t VT_1280X1024_60 = '{
    h_visible: 1280, h_fp: 48, h_sync: 112, h_bp: 248,
    v_visible: 1024, v_fp: 1,  v_sync: 3,   v_bp: 38,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam timing_preset_t VT_640X480_60 = '{
    h_visible: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_visible: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  function automatic int seg_total(input int bp, input int vis, input int fp, input int sync);
    return bp + vis + fp + sync;
  endfunction

  function automatic logic in_visible(input int c, input int bp, input int vis);
    return (c >= bp) && (c < bp + vis);
  endfunction

  // Sync is the final segment, so the upper bound is the wrap point itself.
  function automatic logic in_sync(input int c, input int bp, input int vis, input int fp);
    return c >= bp + vis + fp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis: one axis (horizontal or vertical) of the raster generator.
//
// Ports:
//   clk        in  clock
//   clr_n      in  async active-low reset
//   adv        in  advance the counter by one this cycle
//   cnt        out registered count, 0..TOTAL-1
//   blank      out registered, 1 outside the visible segment
//   sync       out registered, POL inside the sync segment, else ~POL
//   blank_next out combinational blank for the count about to be loaded
//   coord_next out combinational visible coordinate (0 when blanked) for the
//                  count about to be loaded
//   wrap_now   out combinational, 1 when this cycle's advance wraps to 0
//
// Every registered output is decoded from the next count, so it lines up
// with cnt in the same cycle. The *_next outputs let the parent register its
// own cross-axis outputs (de, win, x, y, pulses) with the same alignment.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int   BP   = 1,
  parameter int   VIS  = 1,
  parameter int   FP   = 1,
  parameter int   SYNC = 1,
  parameter logic POL  = 1'b1,
  parameter int   CW   = 11
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          blank,
  output logic          sync,
  output logic          blank_next,
  output logic [CW-1:0] coord_next,
  output logic          wrap_now
);

  localparam int            TOTAL    = seg_total(BP, VIS, FP, SYNC);
  localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);
  localparam logic [CW-1:0] BP_CNT   = CW'(BP);

  logic [CW-1:0] cnt_next;
  logic          sync_next;

  always_comb begin
    cnt_next = cnt;
    wrap_now = 1'b0;
    if (adv) begin
      if (cnt == LAST_CNT) begin
        cnt_next = '0;
        wrap_now = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
    blank_next = !in_visible(int'(cnt_next), BP, VIS);
    sync_next  = in_sync(int'(cnt_next), BP, VIS, FP) ? POL : ~POL;
    coord_next = blank_next ? '0 : (cnt_next - BP_CNT);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      blank <= 1'b1;
      sync  <= ~POL;
    end else begin
      cnt   <= cnt_next;
      blank <= blank_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (counters, blanking, sync,
// active-area coordinates and a vertical text window).
//
// Ports:
//   px_clk       in  pixel clock
//   clr_n        in  async active-low reset
//   en           in  count enable; when low everything holds, pulses are 0
//   hsync/vsync  out sync, active level HS_POL/VS_POL
//   hblank/vblank out 1 outside the visible segment of each axis
//   de           out visible pixel
//   win          out visible pixel on a line inside [WIN_Y0, WIN_Y0+WIN_LINES)
//   hc/vc        out raw counters
//   x/y          out active-area coordinates (0 when that axis is blanked)
//   line_start   out 1 in the cycle after hc wrapped to 0
//   frame_start  out 1 in the cycle after hc and vc both wrapped to 0
//
// All outputs are registers loaded from next-state decodes, so they share
// a single cycle of alignment with hc/vc.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = VT_1280X1024_60.h_visible,
  parameter int H_FP      = VT_1280X1024_60.h_fp,
  parameter int H_SYNC    = VT_1280X1024_60.h_sync,
  parameter int H_BP      = VT_1280X1024_60.h_bp,
  parameter int V_VISIBLE = VT_1280X1024_60.v_visible,
  parameter int V_FP      = VT_1280X1024_60.v_fp,
  parameter int V_SYNC    = VT_1280X1024_60.v_sync,
  parameter int V_BP      = VT_1280X1024_60.v_bp,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int WIN_Y0    = 112,
  parameter int WIN_LINES = 800,
  parameter int CW        = 11
) (
  input  logic          px_clk,
  input  logic          clr_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          win,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = seg_total(H_BP, H_VISIBLE, H_FP, H_SYNC);
  localparam int V_TOTAL = seg_total(V_BP, V_VISIBLE, V_FP, V_SYNC);

  if (H_TOTAL > (2 ** CW)) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (2 ** CW)) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (WIN_Y0 + WIN_LINES > V_VISIBLE) begin : g_bad_window
    $error("video_timing_gen: text window extends past the visible lines");
  end

  logic          h_blank_next;
  logic          v_blank_next;
  logic          h_wrap_now;
  logic          v_wrap_now;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          de_next;
  logic          win_next;

  timing_axis #(
    .BP(H_BP), .VIS(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .clk        (px_clk),
    .clr_n      (clr_n),
    .adv        (en),
    .cnt        (hc),
    .blank      (hblank),
    .sync       (hsync),
    .blank_next (h_blank_next),
    .coord_next (x_next),
    .wrap_now   (h_wrap_now)
  );

  // The vertical axis steps only on the cycle the horizontal axis wraps.
  timing_axis #(
    .BP(V_BP), .VIS(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .clk        (px_clk),
    .clr_n      (clr_n),
    .adv        (h_wrap_now),
    .cnt        (vc),
    .blank      (vblank),
    .sync       (vsync),
    .blank_next (v_blank_next),
    .coord_next (y_next),
    .wrap_now   (v_wrap_now)
  );

  always_comb begin
    de_next  = ~h_blank_next & ~v_blank_next;
    win_next = de_next && (int'(y_next) >= WIN_Y0) && (int'(y_next) < WIN_Y0 + WIN_LINES);
  end

  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      win         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      de          <= de_next;
      win         <= win_next;
      // Wraps only occur on enabled cycles, so both pulses drop while en=0.
      line_start  <= h_wrap_now;
      frame_start <= h_wrap_now & v_wrap_now;
    end
  end

endmodule
